// File: rtl/imm_encoder.sv
// Immediate encoder: finds the lowest-index permitted ImmSrc mode whose extension
// reproduces a 32-bit value, trying one mode per clock in a small IDLE/CHECK/DONE FSM.
module imm_encoder (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] Value,
  input  logic [3:0]  ModeMask,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [23:0] Instr,
  output logic [1:0]  ImmSrc,
  output logic        Encodable
);

  typedef enum logic [1:0] {IDLE, CHECK, DONE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] val_q, val_d;
  logic [3:0]  mask_q, mask_d;
  logic [23:0] instr_q, instr_d;
  logic [1:0]  imm_src_q, imm_src_d;
  logic        encodable_q, encodable_d;

  logic [23:0] cand;
  logic        match;

  function automatic logic [23:0] candidate(input logic [1:0] mode, input logic [31:0] v);
    case (mode)
      2'b00:   candidate = {16'b0, v[7:0]};
      2'b01:   candidate = {12'b0, v[11:0]};
      2'b10:   candidate = v[25:2];
      default: candidate = {12'b0, v[31:20]};
    endcase
  endfunction

  // Same rules as the immediate extender this block inverts.
  function automatic logic [31:0] extend(input logic [1:0] mode, input logic [23:0] f);
    case (mode)
      2'b00:   extend = {24'b0, f[7:0]};
      2'b01:   extend = {20'b0, f[11:0]};
      2'b10:   extend = {{6{f[23]}}, f, 2'b00};
      default: extend = {f[11:0], 20'b0};
    endcase
  endfunction

  assign cand  = candidate(idx_q, val_q);
  assign match = mask_q[idx_q] && (extend(idx_q, cand) == val_q);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    val_d       = val_q;
    mask_d      = mask_q;
    instr_d     = instr_q;
    imm_src_d   = imm_src_q;
    encodable_d = encodable_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          val_d   = Value;
          mask_d  = ModeMask;
          idx_d   = 2'd0;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (match) begin
          instr_d     = cand;
          imm_src_d   = idx_q;
          encodable_d = 1'b1;
          state_d     = DONE;
        end else if (idx_q != 2'd3) begin
          idx_d = idx_q + 2'd1;
        end else begin
          instr_d     = 24'd0;
          imm_src_d   = 2'b00;
          encodable_d = 1'b0;
          state_d     = DONE;
        end
      end
      DONE: begin
        // No bypass to CHECK: a new request is only taken from IDLE.
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      idx_q       <= 2'd0;
      val_q       <= 32'd0;
      mask_q      <= 4'd0;
      instr_q     <= 24'd0;
      imm_src_q   <= 2'b00;
      encodable_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      val_q       <= val_d;
      mask_q      <= mask_d;
      instr_q     <= instr_d;
      imm_src_q   <= imm_src_d;
      encodable_q <= encodable_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign Instr     = instr_q;
  assign ImmSrc    = imm_src_q;
  assign Encodable = encodable_q;

endmodule
